// File: rtl/rotor1_reverse.sv
// Rotor-1 return path: undoes the rotation offset and inverts the rotor-1 wiring, and also owns the rotor position.
// Two-stage elastic valid/ready pipeline: 2-cycle latency, 1 token/cycle, stalls hold both stages without loss.
module rotor1_reverse #(
    parameter int unsigned POS_RESET = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [4:0] load_pos,
    input  logic       step,
    output logic [4:0] pos,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [4:0] in,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [4:0] out,
    output logic       err
);

    localparam logic [4:0] LP_POS_RESET = 5'(POS_RESET);

    logic [4:0] r_pos;
    logic       r_s1_vld;
    logic [4:0] r_s1_t;
    logic       r_s1_err;
    logic       r_s2_vld;
    logic [4:0] r_out;
    logic       r_err;

    logic [4:0] w_load_mod;
    logic [5:0] w_sum;
    logic [4:0] w_t;
    logic [4:0] w_m;
    logic       w_s2_adv;
    logic       w_accept;

    function automatic logic [4:0] invmap(input logic [4:0] m);
        case (m)
            5'd1:    invmap = 5'd15;
            5'd2:    invmap = 5'd24;
            5'd3:    invmap = 5'd8;
            5'd4:    invmap = 5'd4;
            5'd5:    invmap = 5'd23;
            5'd6:    invmap = 5'd17;
            5'd7:    invmap = 5'd6;
            5'd8:    invmap = 5'd9;
            5'd9:    invmap = 5'd20;
            5'd10:   invmap = 5'd21;
            5'd11:   invmap = 5'd12;
            5'd12:   invmap = 5'd26;
            5'd13:   invmap = 5'd3;
            5'd14:   invmap = 5'd7;
            5'd15:   invmap = 5'd16;
            5'd16:   invmap = 5'd1;
            5'd17:   invmap = 5'd5;
            5'd18:   invmap = 5'd14;
            5'd19:   invmap = 5'd10;
            5'd20:   invmap = 5'd22;
            5'd21:   invmap = 5'd19;
            5'd22:   invmap = 5'd11;
            5'd23:   invmap = 5'd13;
            5'd24:   invmap = 5'd18;
            5'd25:   invmap = 5'd2;
            5'd26:   invmap = 5'd25;
            default: invmap = 5'd0;
        endcase
    endfunction

    assign w_load_mod = (load_pos > 5'd25) ? load_pos - 5'd26 : load_pos;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pos <= LP_POS_RESET;
        end else if (load) begin
            r_pos <= w_load_mod;
        end else if (step) begin
            r_pos <= (r_pos == 5'd25) ? 5'd0 : r_pos + 5'd1;
        end
    end

    // in + 26 - pos spans 1..57, so at most two subtractions of 26 reduce it
    assign w_sum = {1'b0, in} + 6'd26 - {1'b0, r_pos};
    always_comb begin
        w_t = w_sum[4:0];
        if (w_sum >= 6'd52) begin
            w_t = 5'(w_sum - 6'd52);
        end else if (w_sum >= 6'd26) begin
            w_t = 5'(w_sum - 6'd26);
        end
    end

    assign w_s2_adv = !r_s2_vld || out_ready;
    assign in_ready = !r_s1_vld || w_s2_adv;
    assign w_accept = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_vld <= 1'b0;
            r_s1_t   <= 5'd0;
            r_s1_err <= 1'b0;
        end else if (in_ready) begin
            r_s1_vld <= in_valid;
            if (w_accept) begin
                r_s1_t   <= w_t;
                r_s1_err <= (in > 5'd25);
            end
        end
    end

    assign w_m = (r_s1_t == 5'd0) ? 5'd26 : r_s1_t;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_vld <= 1'b0;
            r_out    <= 5'd0;
            r_err    <= 1'b0;
        end else if (w_s2_adv) begin
            r_s2_vld <= r_s1_vld;
            if (r_s1_vld) begin
                r_out <= r_s1_err ? 5'd0 : invmap(w_m);
                r_err <= r_s1_err;
            end
        end
    end

    assign pos       = r_pos;
    assign out_valid = r_s2_vld;
    assign out       = r_out;
    assign err       = r_err;

endmodule

// File: tb/tb_rotor1_reverse.sv
// Directed bench for rotor1_reverse: arithmetic reference model with a per-cycle scoreboard plus literal spot checks.
module tb_rotor1_reverse;

    localparam int POS_RESET = 0;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       load;
    logic [4:0] load_pos;
    logic       step;
    logic [4:0] pos;
    logic       in_valid;
    logic       in_ready;
    logic [4:0] in_d;
    logic       out_valid;
    logic       out_ready;
    logic [4:0] out_d;
    logic       err;

    int checks = 0;
    int errors = 0;

    bit         tb_ov = 1'b0;
    logic [4:0] tb_ox = 5'd0;

    logic [5:0] q[$];
    int         mpos = POS_RESET;
    bit         prev_stall = 1'b0;
    logic [4:0] prev_out;
    logic       prev_err;

    int inv_tab [0:26] = '{0, 15, 24, 8, 4, 23, 17, 6, 9, 20, 21, 12, 26, 3,
                           7, 16, 1, 5, 14, 10, 22, 19, 11, 13, 18, 2, 25};

    rotor1_reverse #(.POS_RESET(POS_RESET)) dut (
        .clk(clk), .rst_n(rst_n), .load(load), .load_pos(load_pos), .step(step),
        .pos(pos), .in_valid(in_valid), .in_ready(in_ready), .in(in_d),
        .out_valid(out_valid), .out_ready(out_ready), .out(out_d), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Expected {err, out} for a letter seen at rotor position p.
    function automatic logic [5:0] model(input int v, input int p);
        int t;
        int m;
        if (v > 25) return 6'b100000;
        t = ((v - p) % 26 + 26) % 26;
        m = (t == 0) ? 26 : t;
        return {1'b0, 5'(inv_tab[m])};
    endfunction

    function automatic int fwd_map(input int x);
        for (int m = 1; m <= 26; m++)
            if (inv_tab[m] == x) return m;
        return 0;
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete();
            mpos = POS_RESET;
            prev_stall = 1'b0;
        end else begin
            chk("pos_track", int'(pos), mpos);
            if (prev_stall) begin
                chk("stall_valid", int'(out_valid), 1);
                chk("stall_out", int'(out_d), int'(prev_out));
                chk("stall_err", int'(err), int'(prev_err));
            end
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    chk("unexpected_output", 1, 0);
                end else begin
                    logic [5:0] e;
                    e = q.pop_front();
                    chk("sb_out", int'(out_d), int'(e[4:0]));
                    chk("sb_err", int'(err), int'(e[5]));
                end
            end
            if (in_valid && in_ready)
                q.push_back(tb_ov ? {1'b0, tb_ox} : model(int'(in_d), mpos));
            prev_stall = out_valid && !out_ready;
            prev_out   = out_d;
            prev_err   = err;
            if (load) mpos = int'(load_pos) % 26;
            else if (step) mpos = (mpos + 1) % 26;
        end
    end

    // All stimulus tasks start and end at posedge+1.
    task automatic set_pos(input bit ld, input logic [4:0] lp, input bit stp);
        load = ld; load_pos = lp; step = stp;
        @(posedge clk); #1;
        load = 1'b0; step = 1'b0;
    endtask

    task automatic drive(input logic [4:0] v, input bit stp, input bit ov, input logic [4:0] ox);
        int n;
        in_valid = 1'b1; in_d = v; step = stp; tb_ov = ov; tb_ox = ox;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) chk("accept_timeout", 0, 1);
        @(posedge clk); #1;
        in_valid = 1'b0; step = 1'b0; tb_ov = 1'b0;
    endtask

    task automatic send1(input logic [4:0] v, input bit stp, input int eo, input int ee, input string name);
        int cnt;
        drive(v, stp, 1'b0, 5'd0);
        cnt = 0;
        do begin
            @(negedge clk);
            cnt++;
        end while (!out_valid && cnt < 20);
        chk({name, "_latency"}, cnt, 2);
        chk({name, "_out"}, int'(out_d), eo);
        chk({name, "_err"}, int'(err), ee);
        @(posedge clk); #1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; load = 1'b0; load_pos = 5'd0; step = 1'b0;
        in_valid = 1'b0; in_d = 5'd0; out_ready = 1'b1;
        #12;
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out", int'(out_d), 0);
        chk("rst_err", int'(err), 0);
        chk("rst_pos", int'(pos), POS_RESET);
        #10 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("in_ready_after_reset", int'(in_ready), 1);

        send1(5'd16, 1'b0, 1, 0, "basic");
        set_pos(1'b1, 5'd3, 1'b0);
        chk("load3", int'(pos), 3);
        send1(5'd19, 1'b0, 1, 0, "pos3");
        set_pos(1'b1, 5'd0, 1'b0);
        send1(5'd0, 1'b0, 25, 0, "wrap26");

        set_pos(1'b1, 5'd25, 1'b0);
        set_pos(1'b0, 5'd0, 1'b1);
        chk("step_wrap", int'(pos), 0);
        set_pos(1'b1, 5'd30, 1'b1);
        chk("load_beats_step", int'(pos), 4);

        set_pos(1'b1, 5'd5, 1'b0);
        send1(5'd21, 1'b1, 1, 0, "step_same_edge");
        chk("pos_after_step", int'(pos), 6);

        send1(5'd28, 1'b0, 0, 1, "illegal");

        set_pos(1'b1, 5'd0, 1'b0);
        fork
            begin
                drive(5'd16, 1'b0, 1'b0, 5'd0);
                drive(5'd28, 1'b0, 1'b0, 5'd0);
                drive(5'd0,  1'b0, 1'b0, 5'd0);
                drive(5'd19, 1'b0, 1'b0, 5'd0);
                drive(5'd5,  1'b0, 1'b0, 5'd0);
            end
            begin
                repeat (2) @(posedge clk);
                #1 out_ready = 1'b0;
                @(negedge clk);
                chk("stall_in_ready_low", int'(in_ready), 0);
                chk("stall_hold_valid", int'(out_valid), 1);
                repeat (3) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        repeat (4) @(posedge clk);
        #1;
        chk("stream_drained", q.size(), 0);

        for (int r = 0; r < 26; r++) begin
            set_pos(1'b1, 5'(r), 1'b0);
            for (int x = 1; x <= 26; x++)
                drive(5'((fwd_map(x) + r) % 26), 1'b0, 1'b1, 5'(x));
        end
        repeat (4) @(posedge clk);
        #1;
        chk("roundtrip_drained", q.size(), 0);

        set_pos(1'b1, 5'd7, 1'b0);
        out_ready = 1'b0;
        drive(5'd16, 1'b0, 1'b0, 5'd0);
        drive(5'd19, 1'b0, 1'b0, 5'd0);
        @(negedge clk);
        chk("two_in_flight", int'(out_valid && !in_ready), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", int'(out_valid), 0);
        chk("midrst_pos", int'(pos), POS_RESET);
        chk("midrst_out", int'(out_d), 0);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("no_stale_output", int'(out_valid), 0);
        end
        chk("final_queue_empty", q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rotor1_reverse.md
Name: rotor1_reverse

Overview:
- Return-path (reflector-to-keyboard) stage for rotor 1: the exact inverse of the forward rotor-1 mapping, including removal of the rotation offset.
- Owns the rotor-1 position register (stepping and load).
- Two-stage registered pipeline with valid/ready handshakes on both sides; sits between the reflector output and the plugboard return path.

Parameters:
- POS_RESET, 0, rotor position after reset (0..25).

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- load  input  1  load position from load_pos this cycle
- load_pos  input  5  new position; stored as load_pos mod 26
- step  input  1  advance position by one this cycle
- pos  output  5  current rotor position, 0..25
- in_valid  input  1  input letter valid
- in_ready  output  1  stage can accept input
- in  input  5  forward-domain letter, legal 0..25
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts result
- out  output  5  plaintext-side letter 1..26; 0 on error
- err  output  1  qualifies out: input was illegal (26..31)

Behaviour:
- Reset (async, rst_n=0): pos=POS_RESET, both stage valids=0, out_valid=0, out=0, err=0. in_ready=1 from the first cycle after release.
- Position register:
  - load has priority over step.
  - step increments pos, wrapping 25->0.
  - load and step together: load wins; the step is ignored.
  - pos updates at the clock edge.
- Accept: in_valid && in_ready at an edge captures in and the pre-edge pos. A load or step on the same edge affects only later tokens.
- Stage 1 registers t = (in + 26 - pos_captured) mod 26, using 6-bit intermediate arithmetic. It also registers err1 = (in > 25).
- Stage 2 forms M = (t==0) ? 26 : t, then registers out = invmap(M), or out=0 if err1, and err = err1.
- invmap (M->out):
  - 1->15, 2->24, 3->8, 4->4, 5->23, 6->17, 7->6, 8->9, 9->20
  - 10->21, 11->12, 12->26, 13->3, 14->7, 15->16, 16->1, 17->5, 18->14
  - 19->10, 20->22, 21->19, 22->11, 23->13, 24->18, 25->2, 26->25
- Round trip: for every forward input x in 1..26 and rotate r in 0..25, forward output y = (map(x)+r) mod 26 fed here with pos=r returns x.
- Latency: 2 cycles from accept to out_valid when unstalled. Throughput: 1 token per cycle.
- Handshake:
  - Elastic pipeline. Stage 2 advances when !out_valid || out_ready. Stage 1 advances when stage 2 advances or stage 2 is empty.
  - in_ready = !s1_valid || s1 advances; combinational from out_ready is allowed.
  - While out_valid && !out_ready, out and err are held stable, and no token is dropped or duplicated.
  - A full pipeline with out_ready=0 holds 2 tokens and deasserts in_ready.
- Reset mid-operation flushes all in-flight tokens. No partial output may appear after reset release.
- Illegal input 26..31 produces out=0, err=1 and still consumes one pipeline slot in order.

Test Plan:
- pos=0, in=16 -> out=1, err=0, out_valid exactly 2 cycles after accept.
- load=1, load_pos=3; then in=19 -> out=1. in=0 with pos=0 -> out=25 (M=26 wrap case).
- Exhaustive round trip: all x 1..26 and r 0..25 through the forward model into this block -> out==x every time, err=0.
- pos=25, step=1 -> pos=0. load=1, step=1, load_pos=30 -> pos=4. A token accepted on the same edge as the step uses the old pos.
- Stream 5 tokens with out_ready low for 3 cycles mid-stream:
  - in_ready drops once 2 tokens are held.
  - out stays stable while stalled.
  - All 5 results arrive in order, with no loss and no duplicates.
- in=28 -> out=0, err=1. Assert rst_n=0 with 2 tokens in flight -> out_valid=0 immediately, pos=POS_RESET, and no stale output after release.
